watch_mode_mux: RTL and testbench

WATCH_MODE_MUX -- requirements
Module: watch_mode_mux

---
 rtl/watch_mode_mux.sv | 126 ++++++++++++
 tb/tb_watch_mode_mux.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/watch_mode_mux.sv
// Display-mode multiplexer: selects one character source for the LCD, switching modes only at a frame boundary.
// Optional macro MODE_TIMEOUT_EN adds an inactivity auto-return to mode 0.
module watch_mode_mux #(
    parameter int unsigned N_MODES    = 4,
    parameter int unsigned MODE_W     = 2,
    parameter int unsigned CHAR_W     = 8,
    parameter int unsigned INDEX_W    = 5,
    parameter int unsigned LAST_INDEX = 31,
    parameter int unsigned TIMEOUT_S  = 30
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en_1hz,
    input  logic [MODE_W-1:0]          mode_req,
    input  logic [3:0]                 sw_in,
    input  logic [INDEX_W-1:0]         index_char,
    input  logic [N_MODES*CHAR_W-1:0]  data_in,
    output logic [CHAR_W-1:0]          data_char,
    output logic [MODE_W-1:0]          mode_act,
    output logic [N_MODES-1:0]         mode_en,
    output logic                       pending,
    output logic                       timeout
);

    typedef enum logic {
        ST_STEADY = 1'b0,
        ST_PEND   = 1'b1
    } state_t;

    state_t              r_state;
    logic [MODE_W-1:0]   r_sync1;
    logic [MODE_W-1:0]   r_sync2;
    logic [MODE_W-1:0]   w_req;
    logic [MODE_W-1:0]   w_target;
    logic                w_frame_end;

    // Two-flop synchroniser for the asynchronous DIP-switch request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= mode_req;
            r_sync2 <= r_sync1;
        end
    end

    assign w_req       = (32'(r_sync2) < N_MODES) ? r_sync2 : '0;
    assign w_frame_end = (index_char == INDEX_W'(LAST_INDEX));

`ifdef MODE_TIMEOUT_EN
    logic [MODE_W-1:0] r_sync_prev;
    logic [7:0]        r_idle_cnt;
    logic              w_req_chg;

    assign w_req_chg = (r_sync2 != r_sync_prev);

    // Saturating idle-seconds counter; the override holds until the switches move
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync_prev <= '0;
            r_idle_cnt  <= 8'd0;
            timeout     <= 1'b0;
        end else begin
            r_sync_prev <= r_sync2;
            if ((sw_in != 4'd0) || w_req_chg) begin
                r_idle_cnt <= 8'd0;
            end else if (en_1hz && (r_idle_cnt != 8'hFF)) begin
                r_idle_cnt <= r_idle_cnt + 8'd1;
            end
            if (w_req_chg) begin
                timeout <= 1'b0;
            end else if ((r_idle_cnt >= 8'(TIMEOUT_S)) && (mode_act != '0)) begin
                timeout <= 1'b1;
            end
        end
    end

    assign w_target = timeout ? '0 : w_req;
`else
    logic w_unused_inputs;

    assign w_unused_inputs = ^{en_1hz, sw_in};
    assign timeout         = 1'b0;
    assign w_target        = w_req;
`endif

    // Mode changes are deferred to the last character of a frame so a frame is never mixed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_STEADY;
            mode_act <= '0;
            mode_en  <= N_MODES'(1);
        end else begin
            case (r_state)
                ST_STEADY: begin
                    if (w_target != mode_act) begin
                        r_state <= ST_PEND;
                    end
                end
                ST_PEND: begin
                    if (w_target == mode_act) begin
                        r_state <= ST_STEADY;
                    end else if (w_frame_end) begin
                        mode_act <= w_target;
                        mode_en  <= N_MODES'(1) << w_target;
                        r_state  <= ST_STEADY;
                    end
                end
                default: r_state <= ST_STEADY;
            endcase
        end
    end

    assign pending = (r_state == ST_PEND);

    always_comb begin
        data_char = data_in[CHAR_W-1:0];
        for (int k = 0; k < int'(N_MODES); k++) begin
            if (mode_act == MODE_W'(k)) begin
                data_char = data_in[k*CHAR_W +: CHAR_W];
            end
        end
    end

endmodule

// File: tb/tb_watch_mode_mux.sv
// Self-checking bench for watch_mode_mux: directed vector table, hand sequences, then random stimulus vs a reference model.
module tb_watch_mode_mux;

    localparam int N    = 3;
    localparam int LAST = 31;
    localparam int TS   = 3;
`ifdef MODE_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        en_1hz;
    logic [1:0]  mode_req;
    logic [3:0]  sw_in;
    logic [4:0]  index_char;
    logic [23:0] data_in;
    logic [7:0]  data_char;
    logic [1:0]  mode_act;
    logic [2:0]  mode_en;
    logic        pending;
    logic        timeout;

    int checks   = 0;
    int failures = 0;

    watch_mode_mux #(
        .N_MODES(N), .MODE_W(2), .CHAR_W(8), .INDEX_W(5), .LAST_INDEX(LAST), .TIMEOUT_S(TS)
    ) dut (
        .clk(clk), .rst(rst), .en_1hz(en_1hz), .mode_req(mode_req), .sw_in(sw_in),
        .index_char(index_char), .data_in(data_in), .data_char(data_char),
        .mode_act(mode_act), .mode_en(mode_en), .pending(pending), .timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: requested mode reaches the FSM two clocks late; changes land on a frame end
    int m_act, m_cnt;
    bit m_pend, m_to;
    int hist[$];

    function automatic int hist_at(int d);
        int i = hist.size() - 1 - d;
        return (i >= 0) ? hist[i] : 0;
    endfunction

    task automatic model_reset();
        m_act = 0; m_pend = 1'b0; m_to = 1'b0; m_cnt = 0;
        hist.delete();
    endtask

    task automatic model_step();
        int  seen, prev, tgt, n_act, n_cnt;
        bit  chg, n_pend, n_to;
        hist.push_back(int'(mode_req));
        if (hist.size() > 4) void'(hist.pop_front());
        seen = hist_at(2);
        prev = hist_at(3);
        chg  = (seen != prev);
        tgt  = (TO_EN && m_to) ? 0 : ((seen < N) ? seen : 0);
        n_act = m_act; n_pend = m_pend; n_to = m_to; n_cnt = m_cnt;
        if (!m_pend) begin
            n_pend = (tgt != m_act);
        end else if (tgt == m_act) begin
            n_pend = 1'b0;
        end else if (int'(index_char) == LAST) begin
            n_act  = tgt;
            n_pend = 1'b0;
        end
        if (TO_EN) begin
            if (chg) n_to = 1'b0;
            else if (m_cnt >= TS && m_act != 0) n_to = 1'b1;
            if (sw_in != 4'd0 || chg) n_cnt = 0;
            else if (en_1hz && m_cnt < 255) n_cnt = m_cnt + 1;
        end
        m_act = n_act; m_pend = n_pend; m_to = n_to; m_cnt = n_cnt;
    endtask

    task automatic compare_model(input string tag);
        check({tag, ".mode_act"}, 32'(mode_act), 32'(m_act));
        check({tag, ".mode_en"}, 32'(mode_en), 32'(1) << m_act);
        check({tag, ".pending"}, 32'(pending), 32'(m_pend));
        check({tag, ".timeout"}, 32'(timeout), 32'(m_to));
        check({tag, ".data_char"}, 32'(data_char), 32'(8'(data_in >> (8 * m_act))));
    endtask

    task automatic check_state(input string tag, input int act, input bit pend, input bit to);
        check({tag, ".mode_act"}, 32'(mode_act), 32'(act));
        check({tag, ".mode_en"}, 32'(mode_en), 32'(1) << act);
        check({tag, ".pending"}, 32'(pending), 32'(pend));
        check({tag, ".timeout"}, 32'(timeout), 32'(to));
        check({tag, ".data_char"}, 32'(data_char), 32'(8'h41 + act));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [1:0] req;
        logic [4:0] idx;
        int         act;
        bit         pend;
    } vec_t;

    vec_t tbl[29];

    initial begin
        tbl = '{
            '{2'd0,  5'd0, 0, 1'b0},
            '{2'd1, 5'd10, 0, 1'b0}, '{2'd1, 5'd10, 0, 1'b0}, '{2'd1, 5'd10, 0, 1'b1},
            '{2'd1, 5'd31, 1, 1'b0}, '{2'd1,  5'd0, 1, 1'b0},
            '{2'd2,  5'd5, 1, 1'b0}, '{2'd2,  5'd6, 1, 1'b0}, '{2'd2,  5'd7, 1, 1'b1},
            '{2'd1,  5'd8, 1, 1'b1}, '{2'd1,  5'd9, 1, 1'b1}, '{2'd1, 5'd10, 1, 1'b0},
            '{2'd1, 5'd31, 1, 1'b0},
            '{2'd0, 5'd29, 1, 1'b0}, '{2'd0, 5'd30, 1, 1'b0}, '{2'd0, 5'd31, 1, 1'b1},
            '{2'd0,  5'd0, 1, 1'b1}, '{2'd0, 5'd31, 0, 1'b0},
            '{2'd3,  5'd5, 0, 1'b0}, '{2'd3,  5'd6, 0, 1'b0}, '{2'd3, 5'd31, 0, 1'b0},
            '{2'd3, 5'd31, 0, 1'b0},
            '{2'd1,  5'd0, 0, 1'b0}, '{2'd1,  5'd1, 0, 1'b0}, '{2'd1,  5'd2, 0, 1'b1},
            '{2'd1, 5'd31, 1, 1'b0},
            '{2'd2,  5'd3, 1, 1'b0}, '{2'd2,  5'd4, 1, 1'b0}, '{2'd2,  5'd5, 1, 1'b1}
        };

        rst = 1'b1; en_1hz = 1'b0; mode_req = 2'd0; sw_in = 4'd0; index_char = 5'd0;
        data_in = {8'h43, 8'h42, 8'h41};
        #12;
        check_state("reset", 0, 1'b0, 1'b0);
        rst = 1'b0;

        // Directed vector table: frame-boundary switch, cancel, late detect, out-of-range request
        for (int i = 0; i < 29; i++) begin
            mode_req   = tbl[i].req;
            index_char = tbl[i].idx;
            tick();
            check_state($sformatf("vec%0d", i), tbl[i].act, tbl[i].pend, 1'b0);
        end

        // Asynchronous reset while pending toward mode 2, then re-evaluation after release
        rst = 1'b1;
        #1;
        check_state("rst_mid_pend", 0, 1'b0, 1'b0);
        rst = 1'b0;
        index_char = 5'd0;
        repeat (3) tick();
        check_state("rst_repend", 0, 1'b1, 1'b0);
        index_char = 5'd31;
        tick();
        check_state("rst_switch", 2, 1'b0, 1'b0);
        index_char = 5'd0;

        // Inactivity seconds with no buttons pressed
        for (int p = 0; p < TS; p++) begin
            en_1hz = 1'b1;
            tick();
            en_1hz = 1'b0;
            tick();
        end
`ifdef MODE_TIMEOUT_EN
        check_state("to_set", 2, 1'b0, 1'b1);
        tick();
        check_state("to_pend", 2, 1'b1, 1'b1);
        index_char = 5'd31;
        tick();
        check_state("to_return", 0, 1'b0, 1'b1);
        index_char = 5'd0;
        repeat (4) tick();
        check_state("to_hold", 0, 1'b0, 1'b1);
        mode_req = 2'd1;
        repeat (3) tick();
        check_state("to_clear", 0, 1'b0, 1'b0);
        tick();
        check_state("to_follow_pend", 0, 1'b1, 1'b0);
        index_char = 5'd31;
        tick();
        check_state("to_follow", 1, 1'b0, 1'b0);
`else
        repeat (3) tick();
        check_state("no_timeout", 2, 1'b0, 1'b0);
`endif

        // Randomized run against the reference model
        rst = 1'b1;
        model_reset();
        #1;
        compare_model("rnd_rst");
        rst = 1'b0;
        index_char = 5'd0;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 19) == 0) mode_req = 2'($urandom_range(0, 3));
            index_char = 5'(index_char + 5'd1);
            sw_in      = ($urandom_range(0, 29) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            en_1hz     = ($urandom_range(0, 3) == 0);
            data_in    = 24'($urandom);
            if ($urandom_range(0, 599) == 0) begin
                rst = 1'b1;
                model_reset();
                #1;
                compare_model("rnd_async_rst");
                rst = 1'b0;
            end
            #1;
            compare_model("rnd_pre");
            @(posedge clk);
            model_step();
            #1;
            compare_model("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
